// File: rtl/char_plane_pkg.sv
// rtl/char_plane_pkg.sv - shared constants and state encoding for the character plane writer
//
// Purpose: plane geometry, control character codes, field widths and the
// sequencer state encoding used by char_plane_writer and plane_sweep_counter.
// Ports: none (package).

package char_plane_pkg;

  localparam int ROWS  = 16;
  localparam int COLS  = 40;
  localparam int ROW_W = 4;
  localparam int COL_W = 6;

  localparam logic [7:0] BLANK   = 8'h20;
  localparam logic [7:0] CHAR_NL = 8'h0A;
  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam logic [7:0] CHAR_FF = 8'h0C;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PUT       = 3'd1,
    ST_ERASE     = 3'd2,
    ST_SCROLL    = 3'd3,
    ST_BLANK_ROW = 3'd4,
    ST_CLEAR     = 3'd5
  } state_e;

  // States in which the plane write port is driven.
  function automatic logic is_write_state(input state_e s);
    return (s == ST_PUT) || (s == ST_ERASE) || (s == ST_BLANK_ROW) || (s == ST_CLEAR);
  endfunction

endpackage

// File: rtl/plane_sweep_counter.sv
// rtl/plane_sweep_counter.sv - row-major raster counter used to blank a row or the whole plane
//
// Purpose: holds the current sweep position. start_i loads (start_row_i, 0);
// each advance_i steps one cell row-major. With single_row_i the sweep ends
// at the last column of the start row, otherwise at (ROWS-1, COLS-1).
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-low reset
//   start_i      in   load start position (has priority over advance_i)
//   start_row_i  in   row to start from
//   single_row_i in   sweep only the start row
//   advance_i    in   step to the next cell
//   row_o        out  current sweep row
//   column_o     out  current sweep column
//   done_o       out  current position is the final cell of the sweep

module plane_sweep_counter
  import char_plane_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [ROW_W-1:0] start_row_i,
  input  logic             single_row_i,
  input  logic             advance_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] column_o,
  output logic             done_o
);

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             single_q;

  assign row_o    = row_q;
  assign column_o = col_q;
  assign done_o   = (col_q == LAST_COL) && (single_q || (row_q == LAST_ROW));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_q    <= '0;
      col_q    <= '0;
      single_q <= 1'b0;
    end else if (start_i) begin
      row_q    <= start_row_i;
      col_q    <= '0;
      single_q <= single_row_i;
    end else if (advance_i && !done_o) begin
      // Never steps past the final cell, so row_q cannot leave the plane.
      if (col_q == LAST_COL) begin
        col_q <= '0;
        row_q <= row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/char_plane_writer.sv
// rtl/char_plane_writer.sv - turns a character stream into write/scroll commands for the 16x40 text plane
//
// Purpose: owns the text cursor; handles printable codes, newline, backspace,
// clear-screen, line wrap and scroll on bottom-row overflow.
// Ports:
//   clock            in   system clock
//   reset            in   asynchronous active-low reset
//   in_char[7:0]     in   character code from the source
//   in_valid         in   in_char is valid
//   in_ready         out  a character can be accepted this cycle
//   wr_we            out  plane write enable
//   wr_row[3:0]      out  plane write row
//   wr_column[5:0]   out  plane write column
//   wr_character_id  out  plane write data
//   push_up          out  one-cycle scroll command
//   cursor_row       out  cursor row
//   cursor_column    out  cursor column
//   busy             out  sequencer is not idle

module char_plane_writer
  import char_plane_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       in_char,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_we,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_column,
  output logic [7:0]       wr_character_id,
  output logic             push_up,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_column,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] wr_row_q, wr_row_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [7:0]       wr_data_q, wr_data_d;

  logic             sw_start;
  logic [ROW_W-1:0] sw_start_row;
  logic             sw_single;
  logic             sw_advance;
  logic [ROW_W-1:0] sw_row;
  logic [COL_W-1:0] sw_col;
  logic             sw_done;
  logic             sweeping;
  logic             accept;

  plane_sweep_counter u_sweep (
    .clock        (clock),
    .reset        (reset),
    .start_i      (sw_start),
    .start_row_i  (sw_start_row),
    .single_row_i (sw_single),
    .advance_i    (sw_advance),
    .row_o        (sw_row),
    .column_o     (sw_col),
    .done_o       (sw_done)
  );

  // Gating with reset keeps in_ready low while reset is held even though the
  // state register already reads IDLE.
  assign in_ready = (state_q == ST_IDLE) && reset;
  assign busy     = (state_q != ST_IDLE);
  assign wr_we    = is_write_state(state_q);
  assign push_up  = (state_q == ST_SCROLL);
  assign accept   = in_valid && in_ready;
  assign sweeping = (state_q == ST_BLANK_ROW) || (state_q == ST_CLEAR);

  // During a sweep the address comes straight from the counter; the holding
  // registers track it so the last swept cell persists afterwards.
  assign wr_row          = sweeping ? sw_row : wr_row_q;
  assign wr_column       = sweeping ? sw_col : wr_col_q;
  assign wr_character_id = wr_data_q;

  assign cursor_row    = row_q;
  assign cursor_column = col_q;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    wr_data_d    = wr_data_q;
    sw_start     = 1'b0;
    sw_start_row = '0;
    sw_single    = 1'b0;
    sw_advance   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (in_char)
            CHAR_NL: begin
              col_d = '0;
              if (row_q < LAST_ROW) row_d = row_q + ROW_W'(1);
              else                  state_d = ST_SCROLL;
            end
            CHAR_BS: begin
              if (col_q != '0) begin
                col_d     = col_q - COL_W'(1);
                wr_row_d  = row_q;
                wr_col_d  = col_q - COL_W'(1);
                wr_data_d = BLANK;
                state_d   = ST_ERASE;
              end
            end
            CHAR_FF: begin
              sw_start     = 1'b1;
              sw_start_row = '0;
              sw_single    = 1'b0;
              wr_data_d    = BLANK;
              state_d      = ST_CLEAR;
            end
            default: begin
              wr_row_d  = row_q;
              wr_col_d  = col_q;
              wr_data_d = in_char;
              state_d   = ST_PUT;
            end
          endcase
        end
      end

      ST_PUT: begin
        state_d = ST_IDLE;
        if (col_q < LAST_COL) begin
          col_d = col_q + COL_W'(1);
        end else begin
          col_d = '0;
          if (row_q < LAST_ROW) row_d = row_q + ROW_W'(1);
          else                  state_d = ST_SCROLL;
        end
      end

      ST_ERASE: state_d = ST_IDLE;

      ST_SCROLL: begin
        sw_start     = 1'b1;
        sw_start_row = LAST_ROW;
        sw_single    = 1'b1;
        wr_data_d    = BLANK;
        state_d      = ST_BLANK_ROW;
      end

      ST_BLANK_ROW, ST_CLEAR: begin
        sw_advance = 1'b1;
        wr_row_d   = sw_row;
        wr_col_d   = sw_col;
        if (sw_done) begin
          state_d = ST_IDLE;
          if (state_q == ST_CLEAR) begin
            row_d = '0;
            col_d = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_char_plane_writer.sv
// tb/tb_char_plane_writer.sv - directed self-checking bench for char_plane_writer

module tb_char_plane_writer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       wr_we;
  logic [3:0] wr_row;
  logic [5:0] wr_column;
  logic [7:0] wr_character_id;
  logic       push_up;
  logic [3:0] cursor_row;
  logic [5:0] cursor_column;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  char_plane_writer dut (
    .clock           (clock),
    .reset           (reset),
    .in_char         (in_char),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .wr_we           (wr_we),
    .wr_row          (wr_row),
    .wr_column       (wr_column),
    .wr_character_id (wr_character_id),
    .push_up         (push_up),
    .cursor_row      (cursor_row),
    .cursor_column   (cursor_column),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents c from a negedge, waits for in_ready, lets one rising edge
  // accept it and returns at the following negedge (first post-accept cycle).
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    in_char  = c;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) chk("send_timeout", 32'(n), 32'd0);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int pushes;
    int bad;
    int k;

    // Reset held
    #12;
    chk("rst_wr_we", wr_we, 0);
    chk("rst_push_up", push_up, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_addr", {wr_row, wr_column, wr_character_id}, 0);
    chk("rst_cursor", {cursor_row, cursor_column}, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rel_in_ready", in_ready, 1);

    // First printable
    send(8'h41);
    chk("put_we", wr_we, 1);
    chk("put_addr", {wr_row, wr_column}, {4'd0, 6'd0});
    chk("put_data", wr_character_id, 8'h41);
    chk("put_ready_low", in_ready, 0);
    chk("put_no_push", push_up, 0);
    @(negedge clock);
    chk("put_ready_back", in_ready, 1);
    chk("put_we_off", wr_we, 0);
    chk("put_hold_data", wr_character_id, 8'h41);
    chk("put_cursor", {cursor_row, cursor_column}, {4'd0, 6'd1});

    // Fill row 0 to the last column; wrap to row 1 without scrolling
    pushes = 0;
    for (int i = 1; i < 40; i++) begin
      send(8'h30 + 8'(i % 10));
      if (push_up) pushes++;
      if (i == 39) chk("row0_last_addr", {wr_row, wr_column}, {4'd0, 6'd39});
      @(negedge clock);
      if (push_up) pushes++;
    end
    chk("row0_no_push", pushes, 0);
    chk("row0_wrap_cursor", {cursor_row, cursor_column}, {4'd1, 6'd0});

    // Newlines down to the bottom row
    for (int i = 0; i < 14; i++) send(8'h0A);
    chk("nl_cursor", {cursor_row, cursor_column}, {4'd15, 6'd0});
    chk("nl_not_busy", busy, 0);
    for (int i = 0; i < 39; i++) begin
      send(8'h61);
      @(negedge clock);
    end
    chk("bottom_cursor", {cursor_row, cursor_column}, {4'd15, 6'd39});

    // Printable at (15,39): PUT, SCROLL, 40 blank writes on row 15
    send(8'h42);
    chk("wrap_put_addr", {wr_row, wr_column}, {4'd15, 6'd39});
    chk("wrap_put_data", wr_character_id, 8'h42);
    bad = 0;
    k = 0;
    while (busy && k < 2000) begin
      if (k == 1) begin
        if (!(push_up === 1'b1 && wr_we === 1'b0)) bad++;
      end else if (k >= 2) begin
        if (!(wr_we === 1'b1 && push_up === 1'b0 && wr_row === 4'd15 &&
              wr_column === 6'(k - 2) && wr_character_id === 8'h20)) bad++;
      end
      @(negedge clock);
      k++;
    end
    chk("wrap_sweep_bad_cycles", bad, 0);
    chk("wrap_busy_cycles", k, 42);
    chk("wrap_cursor", {cursor_row, cursor_column}, {4'd15, 6'd0});

    // Newline on the bottom row: SCROLL + 40
    send(8'h0A);
    chk("nlb_push", push_up, 1);
    k = 0;
    while (busy && k < 2000) begin
      @(negedge clock);
      k++;
    end
    chk("nlb_busy_cycles", k, 41);
    chk("nlb_cursor", {cursor_row, cursor_column}, {4'd15, 6'd0});

    // Clear screen: 640 blank writes row-major
    send(8'h0C);
    bad = 0;
    k = 0;
    while (busy && k < 2000) begin
      if (!(wr_we === 1'b1 && in_ready === 1'b0 && push_up === 1'b0 &&
            wr_row === 4'(k / 40) && wr_column === 6'(k % 40) &&
            wr_character_id === 8'h20)) bad++;
      @(negedge clock);
      k++;
    end
    chk("ff_bad_cycles", bad, 0);
    chk("ff_busy_cycles", k, 640);
    chk("ff_last_hold", {wr_row, wr_column}, {4'd15, 6'd39});
    chk("ff_cursor", {cursor_row, cursor_column}, 0);

    // Backspace at column 0 does nothing
    send(8'h0A);
    send(8'h0A);
    send(8'h08);
    chk("bs0_no_we", wr_we, 0);
    chk("bs0_ready", in_ready, 1);
    chk("bs0_cursor", {cursor_row, cursor_column}, {4'd2, 6'd0});

    // Backspace at (2,5) erases (2,4)
    for (int i = 0; i < 5; i++) begin
      send(8'h7A);
      @(negedge clock);
    end
    chk("bs_pre_cursor", {cursor_row, cursor_column}, {4'd2, 6'd5});
    send(8'h08);
    chk("bs_we", wr_we, 1);
    chk("bs_addr", {wr_row, wr_column}, {4'd2, 6'd4});
    chk("bs_data", wr_character_id, 8'h20);
    @(negedge clock);
    chk("bs_idle", in_ready, 1);
    chk("bs_cursor", {cursor_row, cursor_column}, {4'd2, 6'd4});

    // Reset during clear
    send(8'h0C);
    for (int i = 0; i < 100; i++) @(negedge clock);
    chk("mid_clear_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_we", wr_we, 0);
    chk("abort_push", push_up, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cursor", {cursor_row, cursor_column}, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    send(8'h41);
    chk("post_rst_we", wr_we, 1);
    chk("post_rst_addr", {wr_row, wr_column}, 0);
    chk("post_rst_data", wr_character_id, 8'h41);
    wait_idle();
    chk("post_rst_cursor", {cursor_row, cursor_column}, {4'd0, 6'd1});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
